// File: rtl/axi4s_framing_pkg.sv
// Shared types and constants for the AXI4-Stream framing blocks (arbiter, escaper, deescaper).
package axi4s_framing_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_HEADER, ARB_STREAM} arb_state_t;

  localparam logic [7:0] ESCAPE_BYTE = 8'h7F;
  localparam int         MAX_NUM_SRC = 16;

  // A single-source arbiter still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi4s_frame_arbiter_if.sv
// Byte-wide AXI4-Stream bundle: NUM_SRC target streams in, one initiator stream out.
interface axi4s_frame_arbiter_if #(parameter int NUM_SRC = 4);

  logic [NUM_SRC-1:0]      target_tvalid;
  logic [NUM_SRC-1:0]      target_tready;
  logic [NUM_SRC-1:0][7:0] target_tdata;
  logic [NUM_SRC-1:0]      target_tlast;
  logic                    initiator_tvalid;
  logic                    initiator_tready;
  logic [7:0]              initiator_tdata;
  logic                    initiator_tlast;

  // master = the sources plus the downstream sink; slave = the arbiter.
  modport master (
    output target_tvalid, target_tdata, target_tlast, initiator_tready,
    input  target_tready, initiator_tvalid, initiator_tdata, initiator_tlast
  );

  modport slave (
    input  target_tvalid, target_tdata, target_tlast, initiator_tready,
    output target_tready, initiator_tvalid, initiator_tdata, initiator_tlast
  );

endinterface

// File: rtl/axi4s_frame_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant (mod N) wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [IDX_W:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    // Wrap modulo N explicitly so that N need not be a power of two.
    for (int i = 1; i <= N; i++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!grant_any && req[cand[IDX_W-1:0]]) begin
        grant_any                   = 1'b1;
        grant_idx                   = cand[IDX_W-1:0];
        grant_oh[cand[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4s_frame_arbiter.sv
// Frame-locked round-robin arbiter in front of the framing datapath.
// Optional header byte (HDR_BASE + grant index) is enabled with `define FRAME_ARB_HDR_EN.
module axi4s_frame_arbiter
  import axi4s_framing_pkg::*;
#(
  parameter int         NUM_SRC  = 4,
  parameter logic [7:0] HDR_BASE = 8'h00,
  parameter int         IDX_W    = idx_width(NUM_SRC)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi4s_frame_arbiter_if.slave bus,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] grant, last_grant;
  logic [NUM_SRC-1:0] arb_oh;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic             end_of_frame;

  rr_arbiter #(.N(NUM_SRC), .IDX_W(IDX_W)) u_rr (
    .req        (bus.target_tvalid),
    .last_grant (last_grant),
    .grant_oh   (arb_oh),
    .grant_idx  (arb_idx),
    .grant_any  (arb_any)
  );

  assign end_of_frame = bus.target_tvalid[grant] & bus.initiator_tready & bus.target_tlast[grant];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_SRC - 1);
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && arb_any) begin
        grant      <= arb_idx;
        last_grant <= arb_idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:
        if (arb_any) begin
`ifdef FRAME_ARB_HDR_EN
          state_nxt = ARB_HEADER;
`else
          state_nxt = ARB_STREAM;
`endif
        end
      ARB_HEADER: if (bus.initiator_tready) state_nxt = ARB_STREAM;
      ARB_STREAM: if (end_of_frame) state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.target_tready    = '0;
    bus.initiator_tvalid = 1'b0;
    bus.initiator_tdata  = '0;
    bus.initiator_tlast  = 1'b0;
    case (state)
      // The header is ordinary payload; escaping collisions is the escaper's job.
      ARB_HEADER: begin
        bus.initiator_tvalid = 1'b1;
        bus.initiator_tdata  = HDR_BASE + 8'(grant);
      end
      ARB_STREAM: begin
        bus.initiator_tvalid = bus.target_tvalid[grant];
        bus.initiator_tdata  = bus.target_tdata[grant];
        bus.initiator_tlast  = bus.target_tlast[grant];
        bus.target_tready[grant] = bus.initiator_tready;
      end
      default: ;
    endcase
  end

  assign grant_idx = grant;
  assign busy      = (state != ARB_IDLE);

  logic unused;
  assign unused = ^arb_oh;

endmodule

// File: tb/tb_axi4s_frame_arbiter.sv
// Directed bench for axi4s_frame_arbiter: a per-cycle vector table plus reset and header sequences.
module tb_axi4s_frame_arbiter;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [1:0] grant_idx;
  logic       busy;
  int         n_tests = 0;
  int         n_fail = 0;

  axi4s_frame_arbiter_if #(.NUM_SRC(4)) bus ();

  axi4s_frame_arbiter #(.NUM_SRC(4), .HDR_BASE(8'h7D)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .bus       (bus),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [31:0] dat;
    logic        rdy;
    logic        e_vld;
    logic [7:0]  e_dat;
    logic        e_lst;
    logic [3:0]  e_trdy;
    logic        e_busy;
    logic [1:0]  e_gnt;
  } vec_t;

  vec_t vecs[64];
  int   nv;

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] lst, input logic [31:0] dat,
                              input logic rdy, input logic e_vld, input logic [7:0] e_dat,
                              input logic e_lst, input logic [3:0] e_trdy, input logic e_busy,
                              input logic [1:0] e_gnt);
    vec_t v;
    v.vld = vld; v.lst = lst; v.dat = dat; v.rdy = rdy;
    v.e_vld = e_vld; v.e_dat = e_dat; v.e_lst = e_lst;
    v.e_trdy = e_trdy; v.e_busy = e_busy; v.e_gnt = e_gnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] vld, input logic [3:0] lst, input logic [31:0] dat,
                       input logic rdy);
    bus.target_tvalid    = vld;
    bus.target_tlast     = lst;
    bus.target_tdata     = dat;
    bus.initiator_tready = rdy;
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".tvalid"}, 32'(bus.initiator_tvalid), 32'd0);
    chk({name, ".tready"}, 32'(bus.target_tready), 32'd0);
    chk({name, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_beat(input string name, input logic [7:0] d, input logic l, input logic [3:0] trdy,
                          input logic [1:0] g);
    chk({name, ".tvalid"}, 32'(bus.initiator_tvalid), 32'd1);
    chk({name, ".tdata"}, 32'(bus.initiator_tdata), 32'(d));
    chk({name, ".tlast"}, 32'(bus.initiator_tlast), 32'(l));
    chk({name, ".tready"}, 32'(bus.target_tready), 32'(trdy));
    chk({name, ".grant"}, 32'(grant_idx), 32'(g));
  endtask

  initial begin
    nv = 0;
    // all four sources, 3-byte frames -> 0,1,2,3 with one idle cycle between frames
    vecs[nv++] = mk(4'b1111, 4'b0000, 32'h31211101, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
    vecs[nv++] = mk(4'b1111, 4'b0000, 32'h31211101, 1, 1, 8'h01, 0, 4'b0001, 1, 0);
    vecs[nv++] = mk(4'b1111, 4'b0000, 32'h31211102, 1, 1, 8'h02, 0, 4'b0001, 1, 0);
    vecs[nv++] = mk(4'b1111, 4'b0001, 32'h31211103, 1, 1, 8'h03, 1, 4'b0001, 1, 0);
    vecs[nv++] = mk(4'b1110, 4'b0000, 32'h31211100, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
    vecs[nv++] = mk(4'b1110, 4'b0000, 32'h31211100, 1, 1, 8'h11, 0, 4'b0010, 1, 1);
    vecs[nv++] = mk(4'b1110, 4'b0000, 32'h31211200, 1, 1, 8'h12, 0, 4'b0010, 1, 1);
    vecs[nv++] = mk(4'b1110, 4'b0010, 32'h31211300, 1, 1, 8'h13, 1, 4'b0010, 1, 1);
    vecs[nv++] = mk(4'b1100, 4'b0000, 32'h31210000, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
    vecs[nv++] = mk(4'b1100, 4'b0000, 32'h31210000, 1, 1, 8'h21, 0, 4'b0100, 1, 2);
    vecs[nv++] = mk(4'b1100, 4'b0000, 32'h31220000, 1, 1, 8'h22, 0, 4'b0100, 1, 2);
    vecs[nv++] = mk(4'b1100, 4'b0100, 32'h31230000, 1, 1, 8'h23, 1, 4'b0100, 1, 2);
    vecs[nv++] = mk(4'b1000, 4'b0000, 32'h31000000, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
    vecs[nv++] = mk(4'b1000, 4'b0000, 32'h31000000, 1, 1, 8'h31, 0, 4'b1000, 1, 3);
    vecs[nv++] = mk(4'b1000, 4'b0000, 32'h32000000, 1, 1, 8'h32, 0, 4'b1000, 1, 3);
    vecs[nv++] = mk(4'b1000, 4'b1000, 32'h33000000, 1, 1, 8'h33, 1, 4'b1000, 1, 3);
    vecs[nv++] = mk(4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
    // src2 single-byte frame: busy for exactly one cycle
    vecs[nv++] = mk(4'b0100, 4'b0100, 32'h00A50000, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
    vecs[nv++] = mk(4'b0100, 4'b0100, 32'h00A50000, 1, 1, 8'hA5, 1, 4'b0100, 1, 2);
    vecs[nv++] = mk(4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
    // src3 requests while src1 is mid-frame; it waits for src1's tlast
    vecs[nv++] = mk(4'b0010, 4'b0000, 32'h00004100, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
    vecs[nv++] = mk(4'b0010, 4'b0000, 32'h00004100, 1, 1, 8'h41, 0, 4'b0010, 1, 1);
    vecs[nv++] = mk(4'b1010, 4'b1000, 32'h51004200, 1, 1, 8'h42, 0, 4'b0010, 1, 1);
    vecs[nv++] = mk(4'b1010, 4'b1010, 32'h51004300, 1, 1, 8'h43, 1, 4'b0010, 1, 1);
    vecs[nv++] = mk(4'b1000, 4'b1000, 32'h51000000, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
    vecs[nv++] = mk(4'b1000, 4'b1000, 32'h51000000, 1, 1, 8'h51, 1, 4'b1000, 1, 3);
    vecs[nv++] = mk(4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
    // initiator_tready toggling and src0 tvalid gaps; src1 queues behind
    vecs[nv++] = mk(4'b0001, 4'b0000, 32'h00000061, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
    vecs[nv++] = mk(4'b0001, 4'b0000, 32'h00000061, 0, 1, 8'h61, 0, 4'b0000, 1, 0);
    vecs[nv++] = mk(4'b0001, 4'b0000, 32'h00000061, 1, 1, 8'h61, 0, 4'b0001, 1, 0);
    vecs[nv++] = mk(4'b0000, 4'b0000, 32'h00000000, 0, 0, 8'h00, 0, 4'b0000, 1, 0);
    vecs[nv++] = mk(4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 0, 4'b0001, 1, 0);
    vecs[nv++] = mk(4'b0001, 4'b0000, 32'h00000062, 0, 1, 8'h62, 0, 4'b0000, 1, 0);
    vecs[nv++] = mk(4'b0001, 4'b0000, 32'h00000062, 1, 1, 8'h62, 0, 4'b0001, 1, 0);
    vecs[nv++] = mk(4'b0011, 4'b0001, 32'h00007163, 0, 1, 8'h63, 1, 4'b0000, 1, 0);
    vecs[nv++] = mk(4'b0011, 4'b0011, 32'h00007163, 1, 1, 8'h63, 1, 4'b0001, 1, 0);
    vecs[nv++] = mk(4'b0010, 4'b0010, 32'h00007100, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
    vecs[nv++] = mk(4'b0010, 4'b0010, 32'h00007100, 1, 1, 8'h71, 1, 4'b0010, 1, 1);
    vecs[nv++] = mk(4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 0, 4'b0000, 0, 0);

    // reset state
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    repeat (2) @(negedge aclk);
    #1;
    chk_idle("reset");
    chk("reset.grant", 32'(grant_idx), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    for (int i = 0; i < nv; i++) begin
      @(negedge aclk);
      drive(vecs[i].vld, vecs[i].lst, vecs[i].dat, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d.tvalid", i), 32'(bus.initiator_tvalid), 32'(vecs[i].e_vld));
      if (vecs[i].e_vld) begin
        chk($sformatf("v%0d.tdata", i), 32'(bus.initiator_tdata), 32'(vecs[i].e_dat));
        chk($sformatf("v%0d.tlast", i), 32'(bus.initiator_tlast), 32'(vecs[i].e_lst));
      end
      chk($sformatf("v%0d.tready", i), 32'(bus.target_tready), 32'(vecs[i].e_trdy));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_busy) chk($sformatf("v%0d.grant", i), 32'(grant_idx), 32'(vecs[i].e_gnt));
    end

    // reset on byte 2 of a src2 frame, then src0 must win over src2
    @(negedge aclk); drive(4'b0100, 4'b0000, 32'h00810000, 1'b1); #1;
    chk_idle("rst5.arb");
    @(negedge aclk); #1;
    chk_beat("rst5.b1", 8'h81, 1'b0, 4'b0100, 2'd2);
    @(negedge aclk); drive(4'b0100, 4'b0000, 32'h00820000, 1'b1); aresetn = 1'b0; #1;
    chk_idle("rst5.abort");
    chk("rst5.grant", 32'(grant_idx), 32'd0);
    @(negedge aclk); aresetn = 1'b1; drive(4'b0101, 4'b0001, 32'h00830090, 1'b1); #1;
    chk_idle("rst5.idle");
    @(negedge aclk); #1;
    chk_beat("rst5.src0", 8'h90, 1'b1, 4'b0001, 2'd0);
    @(negedge aclk); drive(4'b0000, 4'b0000, 32'h0, 1'b1); #1;
    chk_idle("rst5.end");

    // src2 frame {11,22}; header 7D+2 = 7F only when the header option is built in
    @(negedge aclk); drive(4'b0100, 4'b0000, 32'h00110000, 1'b1); #1;
    chk_idle("hdr.arb");
`ifdef FRAME_ARB_HDR_EN
    @(negedge aclk); #1;
    chk_beat("hdr.hdr", 8'h7F, 1'b0, 4'b0000, 2'd2);
`endif
    @(negedge aclk); #1;
    chk_beat("hdr.b1", 8'h11, 1'b0, 4'b0100, 2'd2);
    @(negedge aclk); drive(4'b0100, 4'b0100, 32'h00220000, 1'b1); #1;
    chk_beat("hdr.b2", 8'h22, 1'b1, 4'b0100, 2'd2);
    @(negedge aclk); drive(4'b0000, 4'b0000, 32'h0, 1'b1); #1;
    chk_idle("hdr.end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
